// File: rtl/rom_region_loader_pkg.sv
// Shared types, limits and the default load-region table for the ROM loader.
package rom_region_loader_pkg;

   localparam int unsigned MAX_REGIONS = 16;
   localparam int unsigned ADDR_W      = 32;
   localparam int unsigned SIZE_W      = 32;
   localparam int unsigned IDX_W       = 4;
   localparam int unsigned START_W     = 5;
   localparam int unsigned HCNT_W      = 6;

   typedef enum logic [3:0] {
      STORAGE_NONE = 4'd0,
      STORAGE_SDR  = 4'd1,
      STORAGE_DDR  = 4'd2,
      STORAGE_BRAM = 4'd3
   } region_storage_t;

   typedef enum logic [1:0] {
      ENCODING_NONE   = 2'd0,
      ENCODING_SWAP16 = 2'd1
   } region_encoding_t;

   typedef struct packed {
      logic [ADDR_W-1:0] base_addr;
      region_storage_t   storage;
      region_encoding_t  encoding;
   } region_t;

   // First header byte lands in the upper half.
   typedef struct packed {
      logic [7:0] game;
      logic [7:0] variant;
   } board_cfg_t;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      HDR_CFG  = 3'd1,
      HDR_SIZE = 3'd2,
      DATA     = 3'd3,
      SKIP     = 3'd4
   } loader_state_t;

   localparam region_t LOAD_REGIONS [6] = '{
      '{base_addr: 32'h0000_0000, storage: STORAGE_SDR,  encoding: ENCODING_NONE},
      '{base_addr: 32'h0010_0000, storage: STORAGE_SDR,  encoding: ENCODING_SWAP16},
      '{base_addr: 32'h3000_0000, storage: STORAGE_DDR,  encoding: ENCODING_NONE},
      '{base_addr: 32'h3080_0000, storage: STORAGE_DDR,  encoding: ENCODING_SWAP16},
      '{base_addr: 32'h0000_0000, storage: STORAGE_BRAM, encoding: ENCODING_NONE},
      '{base_addr: 32'h0000_4000, storage: STORAGE_BRAM, encoding: ENCODING_NONE}
   };

   // Byte address for offset off inside region r; SWAP16 flips the lane within each 16-bit word.
   function automatic logic [ADDR_W-1:0] region_addr(input region_t r, input logic [ADDR_W-1:0] off);
      logic [ADDR_W-1:0] lane;
      lane = {{(ADDR_W-1){1'b0}}, (r.encoding == ENCODING_SWAP16)};
      return r.base_addr + (off ^ lane);
   endfunction

endpackage

// File: rtl/rom_region_loader_region_seek.sv
// Priority finder: lowest index >= start whose region has a nonzero size.
module rom_region_loader_region_seek
   import rom_region_loader_pkg::*;
#(
   parameter int unsigned N = MAX_REGIONS
) (
   input  logic [N-1:0]       nonzero,
   input  logic [START_W-1:0] start,
   output logic [IDX_W-1:0]   idx,
   output logic               found
);

   // Scan downward so the lowest qualifying index wins.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int i = int'(N) - 1; i >= 0; i--) begin
         if (nonzero[i] && (START_W'(i) >= start)) begin
            idx   = IDX_W'(i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rom_region_loader.sv
// Streaming ROM loader: parses board config and region sizes, then routes payload bytes to storage.
module rom_region_loader
   import rom_region_loader_pkg::*;
#(
   parameter int unsigned NUM_REGIONS = 6,
   parameter region_t     REGIONS [NUM_REGIONS] = LOAD_REGIONS
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 ioctl_download,
   input  logic                 ioctl_wr,
   input  logic [7:0]           ioctl_dout,
   output logic                 ioctl_wait,
   output logic                 wr_req,
   input  logic                 wr_ack,
   output region_storage_t      wr_storage,
   output logic [ADDR_W-1:0]    wr_addr,
   output logic [7:0]           wr_data,
   output logic [IDX_W-1:0]     region_idx,
   output board_cfg_t           board_cfg,
   output logic                 board_cfg_valid,
   output logic                 load_done,
   output logic                 excess,
   output logic                 overrun
);

   localparam int unsigned LAST_IDX = NUM_REGIONS - 1;
   localparam logic [HCNT_W-1:0] HDR_LAST = HCNT_W'(NUM_REGIONS * 4 - 1);

   loader_state_t        state;
   logic                 dl_q;
   logic                 cfg_cnt;
   logic [HCNT_W-1:0]    hdr_cnt;
   logic [SIZE_W-1:0]    sizes [MAX_REGIONS];
   logic [ADDR_W-1:0]    off;
   logic [SIZE_W-1:0]    remaining;

   region_t              tab [MAX_REGIONS];
   logic [MAX_REGIONS-1:0] nz;
   logic [SIZE_W-1:0]    last_size;
   logic [START_W-1:0]   seek_start;
   logic [IDX_W-1:0]     seek_idx;
   logic                 seek_found;
   logic [SIZE_W-1:0]    seek_size;

   // Region table padded to the full index space so unused slots read as empty.
   for (genvar g = 0; g < MAX_REGIONS; g++) begin : g_tab
      if (g < NUM_REGIONS) begin : g_used
         assign tab[g] = REGIONS[g];
      end else begin : g_unused
         assign tab[g] = '0;
      end
   end

   // Size of the last region including the byte arriving now (header end decision).
   assign last_size = {sizes[IDX_W'(LAST_IDX)][SIZE_W-9:0], ioctl_dout};

   // Nonzero-size map; during the header the last entry reflects the incoming byte.
   always_comb begin
      nz = '0;
      for (int i = 0; i < int'(MAX_REGIONS); i++) begin
         nz[i] = (sizes[i] != '0);
      end
      if (state == HDR_SIZE) begin
         nz[LAST_IDX] = (last_size != '0);
      end
   end

   // Header end searches from region 0; a finished region searches past itself.
   assign seek_start = (state == HDR_SIZE) ? '0 : (START_W'(region_idx) + START_W'(1));

   rom_region_loader_region_seek #(
      .N (MAX_REGIONS)
   ) u_region_seek (
      .nonzero (nz),
      .start   (seek_start),
      .idx     (seek_idx),
      .found   (seek_found)
   );

   // Byte count for the region being selected, bypassing the not-yet-written last size.
   assign seek_size = ((state == HDR_SIZE) && (seek_idx == IDX_W'(LAST_IDX))) ? last_size
                                                                               : sizes[seek_idx];

   assign ioctl_wait = wr_req;

   // Loader state machine with registered write port and status flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= IDLE;
         dl_q            <= 1'b0;
         cfg_cnt         <= 1'b0;
         hdr_cnt         <= '0;
         off             <= '0;
         remaining       <= '0;
         for (int i = 0; i < int'(MAX_REGIONS); i++) begin
            sizes[i] <= '0;
         end
         wr_req          <= 1'b0;
         wr_storage      <= STORAGE_NONE;
         wr_addr         <= '0;
         wr_data         <= '0;
         region_idx      <= '0;
         board_cfg       <= '0;
         board_cfg_valid <= 1'b0;
         load_done       <= 1'b0;
         excess          <= 1'b0;
         overrun         <= 1'b0;
      end else begin
         dl_q      <= ioctl_download;
         load_done <= 1'b0;

         if ((state != IDLE) && !ioctl_download) begin
            // Download ended: let an outstanding write finish, then report completion.
            if (!wr_req || wr_ack) begin
               wr_req    <= 1'b0;
               load_done <= 1'b1;
               state     <= IDLE;
            end
         end else begin
            case (state)
               IDLE: begin
                  if (ioctl_download && !dl_q) begin
                     cfg_cnt         <= 1'b0;
                     hdr_cnt         <= '0;
                     off             <= '0;
                     remaining       <= '0;
                     region_idx      <= '0;
                     for (int i = 0; i < int'(MAX_REGIONS); i++) begin
                        sizes[i] <= '0;
                     end
                     board_cfg_valid <= 1'b0;
                     excess          <= 1'b0;
                     overrun         <= 1'b0;
                     state           <= HDR_CFG;
                  end
               end

               HDR_CFG: begin
                  if (ioctl_wr) begin
                     if (!cfg_cnt) begin
                        board_cfg.game  <= ioctl_dout;
                        cfg_cnt         <= 1'b1;
                     end else begin
                        board_cfg.variant <= ioctl_dout;
                        board_cfg_valid   <= 1'b1;
                        state             <= HDR_SIZE;
                     end
                  end
               end

               HDR_SIZE: begin
                  if (ioctl_wr) begin
                     sizes[hdr_cnt[HCNT_W-1:2]] <= {sizes[hdr_cnt[HCNT_W-1:2]][SIZE_W-9:0], ioctl_dout};
                     hdr_cnt <= hdr_cnt + HCNT_W'(1);
                     if (hdr_cnt == HDR_LAST) begin
                        if (seek_found) begin
                           region_idx <= seek_idx;
                           off        <= '0;
                           remaining  <= seek_size;
                           state      <= DATA;
                        end else begin
                           state <= SKIP;
                        end
                     end
                  end
               end

               DATA: begin
                  if (wr_req) begin
                     // A byte arriving while a write is pending cannot be buffered.
                     if (ioctl_wr) begin
                        overrun <= 1'b1;
                     end
                     if (wr_ack) begin
                        wr_req <= 1'b0;
                        if (remaining == SIZE_W'(1)) begin
                           if (seek_found) begin
                              region_idx <= seek_idx;
                              off        <= '0;
                              remaining  <= seek_size;
                           end else begin
                              remaining <= '0;
                              state     <= SKIP;
                           end
                        end else begin
                           off       <= off + ADDR_W'(1);
                           remaining <= remaining - SIZE_W'(1);
                        end
                     end
                  end else if (ioctl_wr) begin
                     wr_req     <= 1'b1;
                     wr_storage <= tab[region_idx].storage;
                     wr_addr    <= region_addr(tab[region_idx], off);
                     wr_data    <= ioctl_dout;
                  end
               end

               SKIP: begin
                  if (ioctl_wr) begin
                     excess <= 1'b1;
                  end
               end

               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_rom_region_loader.sv
// Scoreboard bench for rom_region_loader with a three-region table.
module tb_rom_region_loader;
   import rom_region_loader_pkg::*;

   localparam region_t TB_REGIONS [3] = '{
      '{base_addr: 32'h0010_0000, storage: STORAGE_SDR,  encoding: ENCODING_NONE},
      '{base_addr: 32'h2000_0000, storage: STORAGE_DDR,  encoding: ENCODING_SWAP16},
      '{base_addr: 32'hFFFF_FFFE, storage: STORAGE_BRAM, encoding: ENCODING_NONE}
   };

   // Independent view of the table used to predict write targets.
   localparam logic [31:0] BASE [3] = '{32'h0010_0000, 32'h2000_0000, 32'hFFFF_FFFE};
   localparam logic [3:0]  STOR [3] = '{4'd1, 4'd2, 4'd3};
   localparam bit          SWAP [3] = '{1'b0, 1'b1, 1'b0};

   logic            clk;
   logic            reset;
   logic            ioctl_download;
   logic            ioctl_wr;
   logic [7:0]      ioctl_dout;
   logic            ioctl_wait;
   logic            wr_req;
   logic            wr_ack;
   region_storage_t wr_storage;
   logic [31:0]     wr_addr;
   logic [7:0]      wr_data;
   logic [3:0]      region_idx;
   board_cfg_t      board_cfg;
   logic            board_cfg_valid;
   logic            load_done;
   logic            excess;
   logic            overrun;

   rom_region_loader #(
      .NUM_REGIONS (3),
      .REGIONS     (TB_REGIONS)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .ioctl_download  (ioctl_download),
      .ioctl_wr        (ioctl_wr),
      .ioctl_dout      (ioctl_dout),
      .ioctl_wait      (ioctl_wait),
      .wr_req          (wr_req),
      .wr_ack          (wr_ack),
      .wr_storage      (wr_storage),
      .wr_addr         (wr_addr),
      .wr_data         (wr_data),
      .region_idx      (region_idx),
      .board_cfg       (board_cfg),
      .board_cfg_valid (board_cfg_valid),
      .load_done       (load_done),
      .excess          (excess),
      .overrun         (overrun)
   );

   typedef struct {
      logic [3:0]  st;
      logic [31:0] addr;
      logic [7:0]  data;
      logic [3:0]  ridx;
   } exp_t;

   exp_t exp_q [$];

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   int ld_cnt   = 0;
   int ld_cyc   = -1;
   int ack_cyc  = -1;
   int ack_delay = 0;
   bit ack_en   = 1'b1;
   bit stray    = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic void push_exp(input int r, input logic [31:0] off, input logic [7:0] d);
      exp_t e;
      e.st   = STOR[r];
      e.addr = BASE[r] + (SWAP[r] ? (off ^ 32'd1) : off);
      e.data = d;
      e.ridx = 4'(r);
      exp_q.push_back(e);
   endfunction

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // Records every load_done pulse and the cycle it appeared in.
   initial begin
      forever begin
         @(posedge clk);
         #3;
         if (load_done === 1'b1) begin
            ld_cnt++;
            ld_cyc = cyc;
         end
      end
   end

   // Storage model: acknowledges after ack_delay cycles and scores the presented write.
   initial begin
      int wait_cnt;
      wait_cnt = 0;
      wr_ack   = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (ack_en && wr_req && !wr_ack) begin
            if (wait_cnt >= ack_delay) begin
               wr_ack   = 1'b1;
               ack_cyc  = cyc;
               wait_cnt = 0;
               if (exp_q.size() == 0) begin
                  check("unexpected_write", wr_addr, 32'hxxxx_xxxx);
               end else begin
                  exp_t e;
                  e = exp_q.pop_front();
                  check("wr_addr", wr_addr, e.addr);
                  check("wr_data", 32'(wr_data), 32'(e.data));
                  check("wr_storage", 32'(wr_storage), 32'(e.st));
                  check("region_idx", 32'(region_idx), 32'(e.ridx));
               end
            end else begin
               wait_cnt++;
            end
         end else begin
            wr_ack = stray;
            if (!wr_req) wait_cnt = 0;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic strobe(input logic [7:0] b);
      ioctl_wr   = 1'b1;
      ioctl_dout = b;
      @(posedge clk);
      #1;
      ioctl_wr = 1'b0;
   endtask

   task automatic wait_idle_req();
      int n;
      n = 0;
      while (wr_req && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (wr_req) check("wr_req_timeout", 32'(wr_req), 32'd0);
   endtask

   task automatic send_byte(input logic [7:0] b);
      strobe(b);
      wait_idle_req();
   endtask

   task automatic start_load(input logic [7:0] c0, input logic [7:0] c1,
                             input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] s2);
      logic [31:0] s [3];
      s[0] = s0;
      s[1] = s1;
      s[2] = s2;
      ioctl_download = 1'b1;
      @(posedge clk);
      #1;
      send_byte(c0);
      send_byte(c1);
      for (int r = 0; r < 3; r++) begin
         for (int b = 3; b >= 0; b--) begin
            send_byte(s[r][8*b +: 8]);
         end
      end
   endtask

   task automatic end_load(input string tag);
      int ld0;
      int drop_cyc;
      ld0 = ld_cnt;
      ioctl_download = 1'b0;
      drop_cyc = cyc;
      repeat (6) @(posedge clk);
      #1;
      check({tag, "_done_count"}, 32'(ld_cnt - ld0), 32'd1);
      check({tag, "_done_cycle"}, 32'(ld_cyc), 32'(drop_cyc + 1));
      check({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      reset          = 1'b1;
      ioctl_download = 1'b0;
      ioctl_wr       = 1'b0;
      ioctl_dout     = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check("rst_wr_req", 32'(wr_req), 32'd0);
      check("rst_ioctl_wait", 32'(ioctl_wait), 32'd0);
      check("rst_board_cfg", 32'(board_cfg), 32'd0);
      check("rst_cfg_valid", 32'(board_cfg_valid), 32'd0);
      check("rst_load_done", 32'(load_done), 32'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Basic load: two regions, normal and swapped.
      start_load(8'h0A, 8'h00, 32'd2, 32'd1, 32'd0);
      check("t1_board_cfg", 32'(board_cfg), 32'h0000_0A00);
      check("t1_cfg_valid", 32'(board_cfg_valid), 32'd1);
      push_exp(0, 32'd0, 8'h11);
      push_exp(0, 32'd1, 8'h22);
      push_exp(1, 32'd0, 8'h33);
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      check("t1_excess", 32'(excess), 32'd0);
      end_load("t1");

      // Swap16 region with leading empty region, then one byte past the end.
      start_load(8'h12, 8'h34, 32'd0, 32'd4, 32'd0);
      check("t2_board_cfg", 32'(board_cfg), 32'h0000_1234);
      push_exp(1, 32'd0, 8'hA0);
      push_exp(1, 32'd1, 8'hB1);
      push_exp(1, 32'd2, 8'hC2);
      push_exp(1, 32'd3, 8'hD3);
      send_byte(8'hA0);
      send_byte(8'hB1);
      send_byte(8'hC2);
      send_byte(8'hD3);
      check("t2_excess_before", 32'(excess), 32'd0);
      send_byte(8'hEE);
      check("t2_excess_after", 32'(excess), 32'd1);
      end_load("t2");

      // Last region only; its base wraps through the top of the address space.
      start_load(8'h01, 8'h02, 32'd0, 32'd0, 32'd3);
      check("t3_excess_cleared", 32'(excess), 32'd0);
      push_exp(2, 32'd0, 8'h5C);
      push_exp(2, 32'd1, 8'h6D);
      push_exp(2, 32'd2, 8'h7E);
      send_byte(8'h5C);
      send_byte(8'h6D);
      send_byte(8'h7E);
      end_load("t3");

      // Second strobe during a slow acknowledge is dropped and flagged.
      start_load(8'h00, 8'h00, 32'd2, 32'd0, 32'd0);
      check("t4_overrun_before", 32'(overrun), 32'd0);
      ack_delay = 5;
      push_exp(0, 32'd0, 8'h5A);
      strobe(8'h5A);
      check("t4_ioctl_wait", 32'(ioctl_wait), 32'd1);
      @(posedge clk);
      #1;
      strobe(8'hA5);
      wait_idle_req();
      check("t4_overrun_after", 32'(overrun), 32'd1);
      check("t4_queue", 32'(exp_q.size()), 32'd0);
      ack_delay = 0;
      end_load("t4");

      // Download drops while the first payload write is still pending.
      start_load(8'h00, 8'h00, 32'd3, 32'd0, 32'd0);
      check("t5_overrun_cleared", 32'(overrun), 32'd0);
      ack_delay = 4;
      push_exp(0, 32'd0, 8'h77);
      begin
         int ld0;
         int n;
         ld0 = ld_cnt;
         strobe(8'h77);
         ioctl_download = 1'b0;
         n = 0;
         while (ld_cnt == ld0 && n < 30) begin
            @(posedge clk);
            #1;
            n++;
         end
         repeat (3) @(posedge clk);
         #1;
         check("t5_done_count", 32'(ld_cnt - ld0), 32'd1);
         check("t5_done_after_ack", 32'(ld_cyc), 32'(ack_cyc + 1));
         check("t5_queue", 32'(exp_q.size()), 32'd0);
         check("t5_wr_req", 32'(wr_req), 32'd0);
      end
      ack_delay = 0;

      // All sizes zero: every payload byte is excess.
      start_load(8'hFF, 8'h01, 32'd0, 32'd0, 32'd0);
      check("t6_board_cfg", 32'(board_cfg), 32'h0000_FF01);
      send_byte(8'h99);
      check("t6_excess", 32'(excess), 32'd1);
      check("t6_no_req", 32'(wr_req), 32'd0);
      end_load("t6");

      // Reset with a write pending abandons it; a later stray ack does nothing.
      start_load(8'h0A, 8'h0B, 32'd2, 32'd0, 32'd0);
      ack_en = 1'b0;
      strobe(8'h42);
      check("t7_req_pending", 32'(wr_req), 32'd1);
      reset          = 1'b1;
      ioctl_download = 1'b0;
      @(posedge clk);
      #1;
      check("t7_wr_req", 32'(wr_req), 32'd0);
      check("t7_ioctl_wait", 32'(ioctl_wait), 32'd0);
      check("t7_wr_addr", wr_addr, 32'd0);
      check("t7_wr_data", 32'(wr_data), 32'd0);
      check("t7_wr_storage", 32'(wr_storage), 32'd0);
      check("t7_region_idx", 32'(region_idx), 32'd0);
      check("t7_board_cfg", 32'(board_cfg), 32'd0);
      check("t7_cfg_valid", 32'(board_cfg_valid), 32'd0);
      check("t7_excess", 32'(excess), 32'd0);
      check("t7_overrun", 32'(overrun), 32'd0);
      reset = 1'b0;
      exp_q.delete();
      begin
         int ld0;
         ld0   = ld_cnt;
         stray = 1'b1;
         repeat (3) @(posedge clk);
         #1;
         stray = 1'b0;
         strobe(8'h55);
         repeat (3) @(posedge clk);
         #1;
         check("t7_after_wr_req", 32'(wr_req), 32'd0);
         check("t7_after_done", 32'(ld_cnt - ld0), 32'd0);
         check("t7_after_cfg_valid", 32'(board_cfg_valid), 32'd0);
      end
      ack_en = 1'b1;

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
